// File: rtl/term_buffer_if.sv
// Byte-stream input and character read port between the VGA text terminal and term_buffer.
interface term_buffer_if;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic [11:0] charidx;
  logic [7:0]  rd_char;

  modport master (output in_valid, in_char, charidx, input in_ready, rd_char);
  modport slave  (input in_valid, in_char, charidx, output in_ready, rd_char);
endinterface

// File: rtl/term_buffer.sv
// Character screen buffer and cursor engine: circular line offsets give O(1) scrolling,
// a single-write/single-read RAM holds the screen, and reads are served in every state.
module term_buffer #(
  parameter int unsigned TERM_W = 70,
  parameter int unsigned TERM_H = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  term_buffer_if.slave       bus,
  output logic [4:0]         cur_row_o,
  output logic [6:0]         cur_col_o,
  output logic               busy_o
);
  localparam int unsigned TOTAL     = TERM_W * TERM_H;
  localparam logic [11:0] TOTAL_A   = 12'(TOTAL);
  localparam logic [11:0] LINE_A    = 12'(TERM_W);
  localparam logic [11:0] LINE_LAST = 12'(TERM_W - 1);
  localparam logic [11:0] ALL_LAST  = 12'(TOTAL - 1);
  localparam logic [6:0]  COL_LAST  = 7'(TERM_W - 1);
  localparam logic [4:0]  ROW_LAST  = 5'(TERM_H - 1);
  localparam logic [7:0]  SPACE     = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_CLR_LINE, S_CLR_ALL} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [6:0]  cur_col_q, cur_col_d;
  logic [11:0] top_base_q, top_base_d;
  logic [11:0] cur_base_q, cur_base_d;
  logic [11:0] clr_ptr_q, clr_ptr_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic        nl_req;
  logic        is_print;

  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic [12:0] rd_sum;
  logic [11:0] rd_addr;
  logic [7:0]  rd_char_q;
  logic [7:0]  mem [TOTAL];

  // Advance a line-start address by one line, wrapping inside the circular screen.
  function automatic logic [11:0] next_line(input logic [11:0] base);
    logic [12:0] sum;
    sum = {1'b0, base} + {1'b0, LINE_A};
    return (sum >= {1'b0, TOTAL_A}) ? 12'(sum - {1'b0, TOTAL_A}) : sum[11:0];
  endfunction

  assign is_print = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLR_ALL;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      top_base_q <= '0;
      cur_base_q <= '0;
      clr_ptr_q  <= '0;
      clr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      top_base_q <= top_base_d;
      cur_base_q <= cur_base_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    top_base_d = top_base_q;
    cur_base_d = cur_base_q;
    clr_ptr_d  = clr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    nl_req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (is_print) begin
            if (cur_col_q == COL_LAST) begin
              cur_col_d = '0;
              nl_req    = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end else begin
            case (bus.in_char)
              8'h0A: nl_req = 1'b1;
              8'h0D: cur_col_d = '0;
              8'h08: if (cur_col_q != '0) cur_col_d = cur_col_q - 7'd1;
              8'h0C: begin
                cur_col_d  = '0;
                cur_row_d  = '0;
                top_base_d = '0;
                cur_base_d = '0;
                clr_ptr_d  = '0;
                clr_cnt_d  = '0;
                state_d    = S_CLR_ALL;
              end
              default: ;
            endcase
          end
          if (nl_req) begin
            if (cur_row_q != ROW_LAST) begin
              cur_row_d  = cur_row_q + 5'd1;
              cur_base_d = next_line(cur_base_q);
            end else begin
              // Old top line becomes the new bottom line and must be blanked.
              top_base_d = next_line(top_base_q);
              cur_base_d = top_base_q;
              clr_ptr_d  = top_base_q;
              clr_cnt_d  = '0;
              state_d    = S_CLR_LINE;
            end
          end
        end
      end
      S_CLR_LINE: begin
        clr_ptr_d = clr_ptr_q + 12'd1;
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == LINE_LAST) state_d = S_IDLE;
      end
      S_CLR_ALL: begin
        clr_ptr_d = clr_ptr_q + 12'd1;
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == ALL_LAST) state_d = S_IDLE;
      end
      default: state_d = S_CLR_ALL;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    we           = 1'b0;
    waddr        = clr_ptr_q;
    wdata        = SPACE;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && is_print) begin
          we    = 1'b1;
          waddr = cur_base_q + 12'(cur_col_q);
          wdata = bus.in_char;
        end else if (bus.in_valid && bus.in_char == 8'h08 && cur_col_q != '0) begin
          we    = 1'b1;
          waddr = cur_base_q + 12'(cur_col_q - 7'd1);
        end
      end
      S_CLR_LINE, S_CLR_ALL: we = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_sum  = {1'b0, bus.charidx} + {1'b0, top_base_q};
    rd_addr = (rd_sum >= {1'b0, TOTAL_A}) ? 12'(rd_sum - {1'b0, TOTAL_A}) : rd_sum[11:0];
  end

  // NOTE: the RAM has no reset; the full clear after reset is what initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_char_q <= SPACE;
    else        rd_char_q <= mem[rd_addr];
  end

  assign bus.rd_char = rd_char_q;
  assign cur_row_o   = cur_row_q;
  assign cur_col_o   = cur_col_q;
endmodule
